// File: rtl/roman_accumulator_if.sv
// roman_accumulator_if
//   Bundles the letter pulses from the upstream recogniser with the committed
//   result going to the downstream display/checker.
//   master : letter source / result sink (drives I, V, L, U)
//   slave  : the accumulator (drives value, valid, overflow, err, count)
//   I, V, L, U : one-cycle letter pulses (digits 1, 5, 50; U ends a number)
//   value      : last committed number, WIDTH bits
//   valid      : one-cycle pulse on the cycle value updates
//   overflow   : committed number saturated
//   err        : committed number contained an illegal input cycle
//   count      : commits since reset, 8 bits, wrapping
interface roman_accumulator_if #(
  parameter int WIDTH = 12
);
  logic             I;
  logic             V;
  logic             L;
  logic             U;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             overflow;
  logic             err;
  logic [7:0]       count;

  modport master (
    output I, V, L, U,
    input  value, valid, overflow, err, count
  );

  modport slave (
    input  I, V, L, U,
    output value, valid, overflow, err, count
  );
endinterface

// File: rtl/roman_accumulator.sv
// roman_accumulator
//   Turns a string of Roman-numeral letter pulses (I=1, V=5, L=50, with the
//   subtractive rule) into an unsigned number. A U pulse commits the running
//   total to the registered outputs and issues a one-cycle valid pulse.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : roman_accumulator_if slave (letters in, committed result out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   EMPTY | no digit (or illegal cycle) seen yet in the current number
//   ACCUM | at least one digit or illegal cycle seen; U commits
module roman_accumulator #(
  parameter int WIDTH = 12
) (
  input logic                 clk,
  input logic                 reset,
  roman_accumulator_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [WIDTH:0]   ACC_MAX = (WIDTH + 1)'({WIDTH{1'b1}});
  localparam logic [WIDTH+1:0] MAX_EXT = (WIDTH + 2)'({WIDTH{1'b1}});

  state_t           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [5:0]       prev_q, prev_d;
  logic             ovf_f_q, ovf_f_d;
  logic             err_f_q, err_f_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             err_q, err_d;
  logic [7:0]       count_q, count_d;

  logic [2:0]       n_pulses;
  logic             illegal;
  logic             digit_hit;
  logic [5:0]       digit_w;
  logic [WIDTH+1:0] acc_ext;
  logic [WIDTH+1:0] digit_ext;
  logic [WIDTH+1:0] prev_ext;
  logic [WIDTH+1:0] sum_ext;

  assign n_pulses  = 3'(bus.I) + 3'(bus.V) + 3'(bus.L) + 3'(bus.U);
  assign illegal   = (n_pulses > 3'd1);
  assign digit_hit = (n_pulses == 3'd1) && !bus.U;
  assign digit_w   = bus.I ? 6'd1 : (bus.V ? 6'd5 : (bus.L ? 6'd50 : 6'd0));

  // Two guard bits above the WIDTH-bit result so the pre-saturation sum
  // can be compared against the maximum without wrapping.
  assign acc_ext   = (WIDTH + 2)'(acc_q);
  assign digit_ext = (WIDTH + 2)'(digit_w);
  assign prev_ext  = (WIDTH + 2)'(prev_q);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    prev_d     = prev_q;
    ovf_f_d    = ovf_f_q;
    err_f_d    = err_f_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    overflow_d = overflow_q;
    err_d      = err_q;
    count_d    = count_q;
    sum_ext    = '0;

    if (illegal) begin
      // Letters are dropped; the number is still open so a later U commits
      // it with err set.
      err_f_d = 1'b1;
      state_d = ACCUM;
    end else if (digit_hit) begin
      if (state_q == EMPTY) begin
        sum_ext = digit_ext;
      end else if (digit_w > prev_q) begin
        // prev was already added once, so undo it and subtract it once more.
        sum_ext = acc_ext + digit_ext - (prev_ext << 1);
      end else begin
        sum_ext = acc_ext + digit_ext;
      end

      if (ovf_f_q || (sum_ext > MAX_EXT)) begin
        acc_d   = ACC_MAX;
        ovf_f_d = 1'b1;
      end else begin
        acc_d = sum_ext[WIDTH:0];
      end
      prev_d  = digit_w;
      state_d = ACCUM;
    end else if (bus.U && (state_q == ACCUM)) begin
      value_d    = acc_q[WIDTH-1:0];
      overflow_d = ovf_f_q;
      err_d      = err_f_q;
      valid_d    = 1'b1;
      count_d    = count_q + 8'd1;
      acc_d      = '0;
      prev_d     = '0;
      ovf_f_d    = 1'b0;
      err_f_d    = 1'b0;
      state_d    = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      acc_q      <= '0;
      prev_q     <= '0;
      ovf_f_q    <= 1'b0;
      err_f_q    <= 1'b0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      prev_q     <= prev_d;
      ovf_f_q    <= ovf_f_d;
      err_f_q    <= err_f_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign bus.value    = value_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;
  assign bus.err      = err_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_roman_accumulator.sv
// tb_roman_accumulator
//   Directed bench for roman_accumulator: a WIDTH=12 instance for the main
//   behaviour and a WIDTH=6 instance for saturation at a small width.
module tb_roman_accumulator;

  logic clk;
  logic reset;
  logic let_i, let_v, let_l, let_u;
  logic sel6;

  int n_checks;
  int n_errors;
  int exp_cnt;
  int exp_cnt6;

  roman_accumulator_if #(.WIDTH(12)) ra_if ();
  roman_accumulator_if #(.WIDTH(6))  ra6_if ();

  assign ra_if.I  = let_i & ~sel6;
  assign ra_if.V  = let_v & ~sel6;
  assign ra_if.L  = let_l & ~sel6;
  assign ra_if.U  = let_u & ~sel6;
  assign ra6_if.I = let_i & sel6;
  assign ra6_if.V = let_v & sel6;
  assign ra6_if.L = let_l & sel6;
  assign ra6_if.U = let_u & sel6;

  roman_accumulator #(.WIDTH(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ra_if.slave)
  );

  roman_accumulator #(.WIDTH(6)) dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (ra6_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One letter cycle: pulse driven between falling edges so exactly one
  // rising edge samples it; returns on the falling edge after that sample.
  task automatic send(input logic i, input logic v, input logic l, input logic u);
    @(negedge clk);
    let_i = i; let_v = v; let_l = l; let_u = u;
    @(negedge clk);
    let_i = 1'b0; let_v = 1'b0; let_l = 1'b0; let_u = 1'b0;
  endtask

  task automatic send_i(); send(1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic send_v(); send(1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic send_l(); send(1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic send_u(); send(1'b0, 1'b0, 1'b0, 1'b1); endtask

  // Called right after send_u(): checks the commit cycle and the drop of valid.
  task automatic expect_commit(input string tag, input int val, input int ovf, input int er);
    if (sel6) begin
      exp_cnt6 = (exp_cnt6 + 1) % 256;
      check({tag, " valid"},    int'(ra6_if.valid),    1);
      check({tag, " value"},    int'(ra6_if.value),    val);
      check({tag, " overflow"}, int'(ra6_if.overflow), ovf);
      check({tag, " err"},      int'(ra6_if.err),      er);
      check({tag, " count"},    int'(ra6_if.count),    exp_cnt6);
      @(negedge clk);
      check({tag, " valid drop"}, int'(ra6_if.valid), 0);
    end else begin
      exp_cnt = (exp_cnt + 1) % 256;
      check({tag, " valid"},    int'(ra_if.valid),    1);
      check({tag, " value"},    int'(ra_if.value),    val);
      check({tag, " overflow"}, int'(ra_if.overflow), ovf);
      check({tag, " err"},      int'(ra_if.err),      er);
      check({tag, " count"},    int'(ra_if.count),    exp_cnt);
      @(negedge clk);
      check({tag, " valid drop"}, int'(ra_if.valid), 0);
    end
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, " value"},    int'(ra_if.value),    0);
    check({tag, " valid"},    int'(ra_if.valid),    0);
    check({tag, " overflow"}, int'(ra_if.overflow), 0);
    check({tag, " err"},      int'(ra_if.err),      0);
    check({tag, " count"},    int'(ra_if.count),    0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 0;
    exp_cnt6 = 0;
    sel6  = 1'b0;
    let_i = 1'b0; let_v = 1'b0; let_l = 1'b0; let_u = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    expect_reset_outputs("por");
    reset = 1'b1;

    // IV = 4
    send_i(); send_v(); send_u();
    expect_commit("iv", 4, 0, 0);

    // LVII = 57, then IL = 49
    send_l(); send_v(); send_i(); send_i(); send_u();
    expect_commit("lvii", 57, 0, 0);
    send_i(); send_l(); send_u();
    expect_commit("il", 49, 0, 0);

    // U with no digits is ignored and outputs hold
    send_u();
    check("lone_u valid", int'(ra_if.valid), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle valid", int'(ra_if.valid), 0);
    end
    check("hold value", int'(ra_if.value), 49);
    check("hold count", int'(ra_if.count), exp_cnt);
    check("hold overflow", int'(ra_if.overflow), 0);
    check("hold err", int'(ra_if.err), 0);

    // Illegal I+V in EMPTY, then V -> 5 with err; next number clean
    send(1'b1, 1'b1, 1'b0, 1'b0); send_v(); send_u();
    expect_commit("illegal_empty", 5, 0, 1);
    send_v(); send_u();
    expect_commit("after_illegal", 5, 0, 0);

    // U together with a digit is illegal, not a commit
    send_i(); send(1'b1, 1'b0, 1'b0, 1'b1);
    check("digit_u no valid", int'(ra_if.valid), 0);
    send_u();
    expect_commit("digit_u", 1, 0, 1);

    // Saturation at WIDTH=12: 90 L's then I,V stays saturated
    for (int k = 0; k < 90; k++) send_l();
    send_i(); send_v(); send_u();
    expect_commit("sat12", 4095, 1, 0);
    send_i(); send_u();
    expect_commit("post_sat12", 1, 0, 0);

    // WIDTH=6 instance
    sel6 = 1'b1;
    send_l();
    for (int k = 0; k < 13; k++) send_i();
    send_u();
    expect_commit("w6_exact63", 63, 0, 0);
    send_l(); send_l(); send_u();
    expect_commit("w6_ll", 63, 1, 0);
    send_i(); send_u();
    expect_commit("w6_i", 1, 0, 0);
    sel6 = 1'b0;

    // Reset in the middle of a number
    send_l(); send_l();
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    exp_cnt  = 0;
    exp_cnt6 = 0;
    send_i(); send_u();
    expect_commit("after_reset", 1, 0, 0);

    // Count wraps 255 -> 0
    for (int k = 2; k <= 256; k++) begin
      send_i(); send_u();
      exp_cnt = (exp_cnt + 1) % 256;
      if (k == 255) check("count 255", int'(ra_if.count), 255);
    end
    check("wrap count", int'(ra_if.count), 0);
    check("wrap value", int'(ra_if.value), 1);
    check("wrap valid", int'(ra_if.valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
